// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipelined MIPS control unit: opcode and funct
// encodings, ALU control encodings, and the control bundle that travels
// from Decode into the E pipeline register.
//
// Build option: BNE_EN adds the branch_ne bit to the control bundle.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int OPC_W = 6;
  localparam int ALUC_W = 3;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPC_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPC_W-1:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [OPC_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OPC_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OPC_W-1:0] FN_AND = 6'b100100;
  localparam logic [OPC_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OPC_W-1:0] FN_SLT = 6'b101010;

  // ALU control encodings
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

  // Decoded control bundle. An all-zero bundle is a bubble: no register
  // write, no memory write, no branch.
  typedef struct packed {
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch;
`ifdef BNE_EN
    logic              branch_ne;
`endif
    logic              alu_src;
    logic              reg_dst;
    logic [ALUC_W-1:0] alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational main decoder plus ALU decoder for the Decode stage.
//
// Ports:
//   i_opcode  instruction opcode
//   i_funct   R-type funct field
//   o_ctrl    decoded control bundle (CTRL_NOP for anything unrecognised)
//   o_jump    jump request, Decode stage only
//
// Build option: BNE_EN enables decoding of bne into branch_ne.
// ---------------------------------------------------------------------------
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [OPC_W-1:0] i_funct,
  output ctrl_t            o_ctrl,
  output logic             o_jump
);

  logic              w_fn_ok;
  logic [ALUC_W-1:0] w_fn_alu;

  // ALU decoder for R-type funct codes.
  always_comb begin
    w_fn_ok  = 1'b1;
    w_fn_alu = ALU_ADD;
    case (i_funct)
      FN_ADD:  w_fn_alu = ALU_ADD;
      FN_SUB:  w_fn_alu = ALU_SUB;
      FN_AND:  w_fn_alu = ALU_AND;
      FN_OR:   w_fn_alu = ALU_OR;
      FN_SLT:  w_fn_alu = ALU_SLT;
      default: w_fn_ok  = 1'b0;
    endcase
  end

  // Main decoder.
  always_comb begin
    o_ctrl = CTRL_NOP;
    o_jump = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        // An unknown funct leaves the whole bundle as a bubble.
        if (w_fn_ok) begin
          o_ctrl.reg_write = 1'b1;
          o_ctrl.reg_dst   = 1'b1;
          o_ctrl.alu_ctrl  = w_fn_alu;
        end
      end
      OP_LW: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.alu_src    = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.mem_write = 1'b1;
        o_ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_BEQ: begin
        o_ctrl.branch   = 1'b1;
        o_ctrl.alu_ctrl = ALU_SUB;
      end
`ifdef BNE_EN
      OP_BNE: begin
        o_ctrl.branch_ne = 1'b1;
        o_ctrl.alu_ctrl  = ALU_SUB;
      end
`endif
      OP_ADDI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.alu_src   = 1'b1;
        o_ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_J: begin
        o_jump = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_unit
// Pipelined control unit for the 5-stage MIPS core. Decodes Opcode/Funct in
// Decode, carries the control bundle through the E, M and W registers in
// lock-step with the datapath and resolves branches in M.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   Opcode, Funct     Decode-stage instruction fields
//   ZeroM             registered ALU zero flag, Memory stage
//   FlushE            synchronous bubble insert into the E register
//   JumpD             Decode-stage jump request (combinational)
//   RegDstE, ALUSrcE, ALUControlE, RegWriteE, MemToRegE   E-stage controls
//   MemWriteM, RegWriteM, PCSrcM                          M-stage controls
//   MemToRegW, RegWriteW                                  W-stage controls
//
// Build option: BNE_EN adds bne support (BranchNe carried E->M and folded
// into PCSrcM). The port list is the same in both builds.
// ---------------------------------------------------------------------------
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W       = 6,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OP_W-1:0]       Opcode,
  input  logic [OP_W-1:0]       Funct,
  input  logic                  ZeroM,
  input  logic                  FlushE,
  output logic                  JumpD,
  output logic                  RegDstE,
  output logic                  ALUSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  RegWriteE,
  output logic                  MemToRegE,
  output logic                  MemWriteM,
  output logic                  RegWriteM,
  output logic                  PCSrcM,
  output logic                  MemToRegW,
  output logic                  RegWriteW
);

  ctrl_t w_ctrl_d;
  ctrl_t r_ctrl_e;

  logic r_reg_write_m;
  logic r_mem_to_reg_m;
  logic r_mem_write_m;
  logic r_branch_m;
`ifdef BNE_EN
  logic r_branch_ne_m;
`endif
  logic r_reg_write_w;
  logic r_mem_to_reg_w;

  ctrl_decode u_decode (
    .i_opcode (Opcode),
    .i_funct  (Funct),
    .o_ctrl   (w_ctrl_d),
    .o_jump   (JumpD)
  );

  // E register. Reset wins over FlushE; a flush loads a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl_e <= CTRL_NOP;
    end else if (FlushE) begin
      r_ctrl_e <= CTRL_NOP;
    end else begin
      r_ctrl_e <= w_ctrl_d;
    end
  end

  // M register: only the fields still needed past Execute.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write_m  <= 1'b0;
      r_mem_to_reg_m <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_branch_m     <= 1'b0;
`ifdef BNE_EN
      r_branch_ne_m  <= 1'b0;
`endif
    end else begin
      r_reg_write_m  <= r_ctrl_e.reg_write;
      r_mem_to_reg_m <= r_ctrl_e.mem_to_reg;
      r_mem_write_m  <= r_ctrl_e.mem_write;
      r_branch_m     <= r_ctrl_e.branch;
`ifdef BNE_EN
      r_branch_ne_m  <= r_ctrl_e.branch_ne;
`endif
    end
  end

  // W register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_reg_write_w  <= 1'b0;
      r_mem_to_reg_w <= 1'b0;
    end else begin
      r_reg_write_w  <= r_reg_write_m;
      r_mem_to_reg_w <= r_mem_to_reg_m;
    end
  end

  assign RegDstE     = r_ctrl_e.reg_dst;
  assign ALUSrcE     = r_ctrl_e.alu_src;
  assign ALUControlE = r_ctrl_e.alu_ctrl;
  assign RegWriteE   = r_ctrl_e.reg_write;
  assign MemToRegE   = r_ctrl_e.mem_to_reg;

  assign MemWriteM   = r_mem_write_m;
  assign RegWriteM   = r_reg_write_m;

  // Branch resolution is combinational on the registered M-stage bits so
  // it lands in the same cycle ZeroM is valid.
`ifdef BNE_EN
  assign PCSrcM = (r_branch_m & ZeroM) | (r_branch_ne_m & ~ZeroM);
`else
  assign PCSrcM = r_branch_m & ZeroM;
`endif

  assign MemToRegW   = r_mem_to_reg_w;
  assign RegWriteW   = r_reg_write_w;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl_unit
// Directed testbench for pipe_ctrl_unit. Inputs change 1 ns after a rising
// edge; outputs are sampled at that same point, so a value checked after
// step() reflects what the edge just captured.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

  localparam logic [5:0] T_RTYPE = 6'b000000;
  localparam logic [5:0] T_LW    = 6'b100011;
  localparam logic [5:0] T_SW    = 6'b101011;
  localparam logic [5:0] T_BEQ   = 6'b000100;
  localparam logic [5:0] T_BNE   = 6'b000101;
  localparam logic [5:0] T_ADDI  = 6'b001000;
  localparam logic [5:0] T_J     = 6'b000010;
  localparam logic [5:0] T_NOP   = 6'b111111;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       ZeroM;
  logic       FlushE;
  logic       JumpD;
  logic       RegDstE;
  logic       ALUSrcE;
  logic [2:0] ALUControlE;
  logic       RegWriteE;
  logic       MemToRegE;
  logic       MemWriteM;
  logic       RegWriteM;
  logic       PCSrcM;
  logic       MemToRegW;
  logic       RegWriteW;

  int pass_cnt;
  int total_cnt;

  pipe_ctrl_unit dut (
    .clk         (clk),
    .reset       (reset),
    .Opcode      (Opcode),
    .Funct       (Funct),
    .ZeroM       (ZeroM),
    .FlushE      (FlushE),
    .JumpD       (JumpD),
    .RegDstE     (RegDstE),
    .ALUSrcE     (ALUSrcE),
    .ALUControlE (ALUControlE),
    .RegWriteE   (RegWriteE),
    .MemToRegE   (MemToRegE),
    .MemWriteM   (MemWriteM),
    .RegWriteM   (RegWriteM),
    .PCSrcM      (PCSrcM),
    .MemToRegW   (MemToRegW),
    .RegWriteW   (RegWriteW)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // E bundle packed as {RegWrite, MemToReg, ALUSrc, RegDst, ALUControl}.
  function automatic logic [6:0] e_bundle();
    return {RegWriteE, MemToRegE, ALUSrcE, RegDstE, ALUControlE};
  endfunction

  task automatic test_reset();
    reset = 1'b0; Opcode = T_LW; Funct = 6'b0; ZeroM = 1'b1; FlushE = 1'b0;
    step();
    total_cnt++;
    if ({e_bundle(), MemWriteM, RegWriteM, MemToRegW, RegWriteW} !== 11'b0)
      $display("FAIL reset_regs: got %b exp %b",
               {e_bundle(), MemWriteM, RegWriteM, MemToRegW, RegWriteW}, 11'b0);
    else pass_cnt++;
    total_cnt++;
    if (PCSrcM !== 1'b0) $display("FAIL reset_pcsrc: got %b exp 0", PCSrcM);
    else pass_cnt++;
    // Release: lw reaches E on the next edge.
    reset = 1'b1;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b1110_010)
      $display("FAIL reset_release_lw_e: got %b exp %b", e_bundle(), 7'b1110_010);
    else pass_cnt++;
    Opcode = T_NOP; ZeroM = 1'b0;
    step();
    total_cnt++;
    if (RegWriteM !== 1'b1) $display("FAIL lw_m_before_async: got %b exp 1", RegWriteM);
    else pass_cnt++;
    // Asynchronous reset mid-cycle clears M without a clock edge.
    reset = 1'b0;
    #2;
    total_cnt++;
    if ({RegWriteM, MemToRegW, RegWriteW} !== 3'b000)
      $display("FAIL async_reset: got %b exp 000", {RegWriteM, MemToRegW, RegWriteW});
    else pass_cnt++;
    reset = 1'b1;
    step();
    step();
    total_cnt++;
    if ({RegWriteM, RegWriteW} !== 2'b00)
      $display("FAIL reset_no_partial: got %b exp 00", {RegWriteM, RegWriteW});
    else pass_cnt++;
  endtask

  task automatic test_rtype_sub();
    Opcode = T_RTYPE; Funct = 6'b100010;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b1001_110)
      $display("FAIL sub_e: got %b exp %b", e_bundle(), 7'b1001_110);
    else pass_cnt++;
    Opcode = T_NOP;
    step();
    total_cnt++;
    if ({RegWriteM, MemWriteM} !== 2'b10)
      $display("FAIL sub_m: got %b exp 10", {RegWriteM, MemWriteM});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({RegWriteW, MemToRegW} !== 2'b10)
      $display("FAIL sub_w: got %b exp 10", {RegWriteW, MemToRegW});
    else pass_cnt++;
  endtask

  task automatic test_alu_functs();
    logic [5:0] fn_tab [5];
    logic [6:0] exp_tab [5];
    fn_tab  = '{6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    exp_tab = '{7'b1001_010, 7'b1001_000, 7'b1001_001, 7'b1001_111, 7'b0000_000};
    for (int i = 0; i < 5; i++) begin
      Opcode = T_RTYPE; Funct = fn_tab[i];
      step();
      total_cnt++;
      if (e_bundle() !== exp_tab[i])
        $display("FAIL funct_%b: got %b exp %b", fn_tab[i], e_bundle(), exp_tab[i]);
      else pass_cnt++;
    end
    Opcode = T_NOP; Funct = 6'b0;
    step(); step(); step();
  endtask

  task automatic test_lw_sw();
    Opcode = T_LW;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b1110_010)
      $display("FAIL lw_e: got %b exp %b", e_bundle(), 7'b1110_010);
    else pass_cnt++;
    Opcode = T_SW;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b0010_010)
      $display("FAIL sw_e: got %b exp %b", e_bundle(), 7'b0010_010);
    else pass_cnt++;
    total_cnt++;
    if ({RegWriteM, MemWriteM} !== 2'b10)
      $display("FAIL lw_m: got %b exp 10", {RegWriteM, MemWriteM});
    else pass_cnt++;
    Opcode = T_NOP;
    step();
    total_cnt++;
    if ({RegWriteM, MemWriteM} !== 2'b01)
      $display("FAIL sw_m: got %b exp 01", {RegWriteM, MemWriteM});
    else pass_cnt++;
    total_cnt++;
    if ({RegWriteW, MemToRegW} !== 2'b11)
      $display("FAIL lw_w: got %b exp 11", {RegWriteW, MemToRegW});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({RegWriteW, MemToRegW} !== 2'b00)
      $display("FAIL sw_w: got %b exp 00", {RegWriteW, MemToRegW});
    else pass_cnt++;
  endtask

  task automatic test_beq();
    Opcode = T_BEQ; ZeroM = 1'b0;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b0000_110)
      $display("FAIL beq_e: got %b exp %b", e_bundle(), 7'b0000_110);
    else pass_cnt++;
    // Still in E: ZeroM must not take the branch yet.
    ZeroM = 1'b1; #1;
    total_cnt++;
    if (PCSrcM !== 1'b0) $display("FAIL beq_early: got %b exp 0", PCSrcM);
    else pass_cnt++;
    ZeroM = 1'b0; Opcode = T_NOP;
    step();
    ZeroM = 1'b1; #1;
    total_cnt++;
    if (PCSrcM !== 1'b1) $display("FAIL beq_taken: got %b exp 1", PCSrcM);
    else pass_cnt++;
    ZeroM = 1'b0; #1;
    total_cnt++;
    if (PCSrcM !== 1'b0) $display("FAIL beq_not_taken: got %b exp 0", PCSrcM);
    else pass_cnt++;
    ZeroM = 1'b1;
    step();
    total_cnt++;
    if (PCSrcM !== 1'b0) $display("FAIL beq_one_cycle: got %b exp 0", PCSrcM);
    else pass_cnt++;
    ZeroM = 1'b0;
  endtask

  task automatic test_bne();
    Opcode = T_BNE;
    step();
    Opcode = T_NOP;
`ifdef BNE_EN
    total_cnt++;
    if (e_bundle() !== 7'b0000_110)
      $display("FAIL bne_e: got %b exp %b", e_bundle(), 7'b0000_110);
    else pass_cnt++;
    step();
    ZeroM = 1'b0; #1;
    total_cnt++;
    if (PCSrcM !== 1'b1) $display("FAIL bne_taken: got %b exp 1", PCSrcM);
    else pass_cnt++;
    ZeroM = 1'b1; #1;
    total_cnt++;
    if (PCSrcM !== 1'b0) $display("FAIL bne_not_taken: got %b exp 0", PCSrcM);
    else pass_cnt++;
`else
    total_cnt++;
    if (e_bundle() !== 7'b0)
      $display("FAIL bne_unknown_e: got %b exp %b", e_bundle(), 7'b0);
    else pass_cnt++;
    step();
    ZeroM = 1'b0; #1;
    total_cnt++;
    if (PCSrcM !== 1'b0) $display("FAIL bne_unknown_z0: got %b exp 0", PCSrcM);
    else pass_cnt++;
    ZeroM = 1'b1; #1;
    total_cnt++;
    if (PCSrcM !== 1'b0) $display("FAIL bne_unknown_z1: got %b exp 0", PCSrcM);
    else pass_cnt++;
`endif
    ZeroM = 1'b0;
    step();
  endtask

  task automatic test_addi();
    Opcode = T_ADDI;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b1010_010)
      $display("FAIL addi_e: got %b exp %b", e_bundle(), 7'b1010_010);
    else pass_cnt++;
    Opcode = T_NOP;
    step(); step(); step();
  endtask

  task automatic test_flush();
    Opcode = T_RTYPE; Funct = 6'b100000;
    step();
    Opcode = T_ADDI; FlushE = 1'b1;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b0)
      $display("FAIL flush_e: got %b exp %b", e_bundle(), 7'b0);
    else pass_cnt++;
    total_cnt++;
    if (RegWriteM !== 1'b1) $display("FAIL flush_prev_m: got %b exp 1", RegWriteM);
    else pass_cnt++;
    FlushE = 1'b0; Opcode = T_NOP;
    step();
    total_cnt++;
    if ({RegWriteW, RegWriteM} !== 2'b10)
      $display("FAIL flush_prev_w: got %b exp 10", {RegWriteW, RegWriteM});
    else pass_cnt++;
    step(); step();
  endtask

  task automatic test_back_to_back();
    Opcode = T_RTYPE; Funct = 6'b100000;
    step();
    Opcode = T_ADDI; FlushE = 1'b1;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b0)
      $display("FAIL b2b_flush1_e: got %b exp %b", e_bundle(), 7'b0);
    else pass_cnt++;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b0)
      $display("FAIL b2b_flush2_e: got %b exp %b", e_bundle(), 7'b0);
    else pass_cnt++;
    total_cnt++;
    if ({RegWriteM, RegWriteW} !== 2'b01)
      $display("FAIL b2b_mw: got %b exp 01", {RegWriteM, RegWriteW});
    else pass_cnt++;
    FlushE = 1'b0;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b1010_010)
      $display("FAIL b2b_resume_e: got %b exp %b", e_bundle(), 7'b1010_010);
    else pass_cnt++;
    Opcode = T_NOP;
    step(); step(); step();
  endtask

  task automatic test_jump_unknown();
    Opcode = T_J; #1;
    total_cnt++;
    if (JumpD !== 1'b1) $display("FAIL jump_d: got %b exp 1", JumpD);
    else pass_cnt++;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b0)
      $display("FAIL jump_e: got %b exp %b", e_bundle(), 7'b0);
    else pass_cnt++;
    Opcode = T_NOP; #1;
    total_cnt++;
    if (JumpD !== 1'b0) $display("FAIL unknown_jump_d: got %b exp 0", JumpD);
    else pass_cnt++;
    step();
    total_cnt++;
    if (e_bundle() !== 7'b0)
      $display("FAIL unknown_e: got %b exp %b", e_bundle(), 7'b0);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_rtype_sub();
    test_alu_functs();
    test_lw_sw();
    test_beq();
    test_bne();
    test_addi();
    test_flush();
    test_back_to_back();
    test_jump_unknown();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined control unit for the 5-stage MIPS core; the control-side end of the datapath's Opcode/Funct interface.
- Decodes Opcode/Funct in Decode, carries the control bundle through the E, M and W pipeline registers in lock-step with the datapath, and resolves branches in M (PCSrc).
- Exposes the E/M-stage write-enable and memory-to-register bits to a downstream hazard/forwarding unit.

Parameters:
OP_W, 6, opcode and funct field width
ALU_CTRL_W, 3, ALU control field width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
Opcode  in  OP_W  instruction opcode, Decode stage
Funct  in  OP_W  R-type funct field, Decode stage
ZeroM  in  1  registered ALU zero flag, Memory stage
FlushE  in  1  synchronous bubble insert into the E register
JumpD  out  1  Decode-stage jump request (combinational)
RegDstE  out  1  1 = rd destination, 0 = rt destination
ALUSrcE  out  1  1 = SignImm operand, 0 = register operand
ALUControlE  out  ALU_CTRL_W  ALU operation
RegWriteE  out  1  E-stage write enable (hazard unit)
MemToRegE  out  1  E-stage load flag (hazard unit)
MemWriteM  out  1  data-memory write enable
RegWriteM  out  1  M-stage write enable (hazard unit)
PCSrcM  out  1  take branch: BranchM & ZeroM
MemToRegW  out  1  result mux select: 1 = ReadDataW
RegWriteW  out  1  register-file write enable

Behaviour:
- Decode, combinational from Opcode/Funct:
  - 000000 R-type: RegWrite=1, RegDst=1. Funct 100000 add→010, 100010 sub→110, 100100 and→000, 100101 or→001, 101010 slt→111.
  - Unknown funct: full bundle is zero (bubble).
  - 100011 lw: RegWrite, ALUSrc, MemToReg, ALU 010.
  - 101011 sw: ALUSrc, MemWrite, ALU 010.
  - 000100 beq: Branch, ALU 110.
  - 001000 addi: RegWrite, ALUSrc, ALU 010.
  - 000010 j: JumpD=1; all other bits 0.
  - Any other opcode: all-zero bundle.
- Bundle fields: RegWrite, MemToReg, MemWrite, Branch, ALUSrc, RegDst, ALUControl.
- E register: on each rising edge, captures the decoded bundle. If FlushE=1, it captures all-zero instead.
- M register: captures RegWrite, MemToReg, MemWrite and Branch from E every cycle.
- W register: captures RegWrite and MemToReg from M every cycle.
- Latency: an instruction decoded in cycle n drives its E outputs in n+1, M outputs in n+2 and W outputs in n+3.
- PCSrcM = BranchM & ZeroM, combinational, with no added latency.
- JumpD is combinational in Decode and is never registered.
- Reset (reset=0): all E/M/W registers clear to 0 immediately, regardless of the clock. Every registered output reads 0 and PCSrcM=0.
- Reset has priority over FlushE.
- Reset deasserted mid-stream: pipeline restarts with bubbles; no partial bundles survive.
- FlushE affects only the E register. Instructions already in M/W complete normally.
- Back-to-back FlushE inserts one bubble per cycle.
- No stall input: the Decode stage is held by the datapath; the hazard unit pairs StallD with FlushE.
- ALUControlE=000 in a bubble is legal; RegWrite and MemWrite stay 0, so a bubble has no architectural effect.

Optional Feature:
- Macro BNE_EN.
- Defined:
  - Opcode 000101 (bne) decodes as BranchNe=1, ALU 110.
  - BranchNe is carried through E→M.
  - PCSrcM = (BranchM & ZeroM) | (BranchNeM & ~ZeroM).
- Undefined:
  - 000101 is an unknown opcode and decodes to an all-zero bundle.
  - No BranchNe storage exists.
- Port list is identical in both builds.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT)
  - ALU control encodings (ALU_ADD=010, ALU_SUB=110, ALU_AND=000, ALU_OR=001, ALU_SLT=111)
  - control-bundle struct and its all-zero constant CTRL_NOP
- One sub-module, ctrl_decode: pure combinational main decoder plus ALU decoder, Opcode/Funct → bundle + JumpD.
- The top level holds only the E/M/W registers and the PCSrc logic.

Test Plan:
- Reset: hold reset=0 across a clock edge while Opcode=100011 → every registered output is 0 and PCSrcM=0. Release reset → lw bundle appears at E one edge later.
- R-type sub (Opcode=000000, Funct=100010) at cycle 0:
  - cycle 1: ALUControlE=110, RegDstE=1, RegWriteE=1
  - cycle 2: RegWriteM=1, MemWriteM=0
  - cycle 3: RegWriteW=1, MemToRegW=0
- lw then sw:
  - lw: MemToRegE=1, ALUSrcE=1, ALUControlE=010; then MemToRegW=1, RegWriteW=1 three cycles after decode.
  - sw: MemWriteM=1, RegWriteM=0.
- beq:
  - ZeroM=1 in its M cycle → PCSrcM=1 for exactly that cycle.
  - Repeat with ZeroM=0 → PCSrcM=0.
  - With BNE_EN, bne gives the inverse result.
- FlushE=1 while addi (001000) is decoded → E outputs all 0 next cycle. The preceding R-type still reaches RegWriteW=1 on schedule.
- Opcode=000010 → JumpD=1 in the same cycle and all E outputs 0 next cycle. Opcode=111111 → all-zero bundle.
